// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX-stage operand resolution and load-use hazard detection.
// Forwarding selects are computed in ID and latched here. They are applied in EX
// against the current-cycle EX/MEM and MEM/WB values.
module id_ex_stage #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned REG_W   = 5,
  parameter int unsigned ALUOP_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall_in,
  input  logic               flush_in,
  input  logic               id_valid,
  input  logic [DATA_W-1:0]  id_rs_data,
  input  logic [DATA_W-1:0]  id_rt_data,
  input  logic [DATA_W-1:0]  id_imm,
  input  logic [REG_W-1:0]   id_rs,
  input  logic [REG_W-1:0]   id_rt,
  input  logic [REG_W-1:0]   id_rd,
  input  logic               id_uses_rt,
  input  logic               id_regw,
  input  logic               id_memr,
  input  logic               id_memw,
  input  logic               id_alusrc,
  input  logic [ALUOP_W-1:0] id_alu_op,
  input  logic [1:0]         fwd_sel1,
  input  logic [1:0]         fwd_sel2,
  input  logic [DATA_W-1:0]  mem_alu_result,
  input  logic [DATA_W-1:0]  wb_data,
  output logic               load_use_stall,
  output logic               ex_valid,
  output logic [REG_W-1:0]   ex_rd,
  output logic               ex_regw,
  output logic               ex_memr,
  output logic               ex_memw,
  output logic [ALUOP_W-1:0] ex_alu_op,
  output logic [DATA_W-1:0]  ex_opa,
  output logic [DATA_W-1:0]  ex_opb,
  output logic [DATA_W-1:0]  ex_store_data
);

  localparam logic [1:0] SEL_EX  = 2'b10;
  localparam logic [1:0] SEL_MEM = 2'b01;

  typedef enum logic {RUN, HOLD} state_t;

  state_t              state;
  logic                alusrc_q;
  logic [1:0]          sel1_q;
  logic [1:0]          sel2_q;
  logic [DATA_W-1:0]   rs_data_q;
  logic [DATA_W-1:0]   rt_data_q;
  logic [DATA_W-1:0]   imm_q;
  logic [DATA_W-1:0]   hold_opa;
  logic [DATA_W-1:0]   hold_opb;
  logic [DATA_W-1:0]   hold_store;

  logic [DATA_W-1:0]   rs_v;
  logic [DATA_W-1:0]   rt_v;
  logic [DATA_W-1:0]   opb_v;

  // Forwarding mux: EX producer now sits in EX/MEM, MEM producer in MEM/WB.
  always_comb begin
    rs_v = rs_data_q;
    rt_v = rt_data_q;
    if (sel1_q == SEL_EX)       rs_v = mem_alu_result;
    else if (sel1_q == SEL_MEM) rs_v = wb_data;
    if (sel2_q == SEL_EX)       rt_v = mem_alu_result;
    else if (sel2_q == SEL_MEM) rt_v = wb_data;
    opb_v = alusrc_q ? imm_q : rt_v;
  end

  // Operand outputs: live mux while running, frozen copies while held.
  always_comb begin
    ex_opa        = rs_v;
    ex_opb        = opb_v;
    ex_store_data = rt_v;
    if (state == HOLD) begin
      ex_opa        = hold_opa;
      ex_opb        = hold_opb;
      ex_store_data = hold_store;
    end
  end

  // Load in EX whose destination is read by the instruction in ID.
  always_comb begin
    load_use_stall = 1'b0;
    if (state == RUN && !stall_in && ex_valid && ex_memr && ex_rd != '0 &&
        (ex_rd == id_rs || (id_uses_rt && ex_rd == id_rt)))
      load_use_stall = 1'b1;
  end

  // Pipeline register update: rst > flush > stall > load-use bubble > capture.
  always_ff @(posedge clk) begin
    if (rst || flush_in) begin
      state      <= RUN;
      ex_valid   <= 1'b0;
      ex_rd      <= '0;
      ex_regw    <= 1'b0;
      ex_memr    <= 1'b0;
      ex_memw    <= 1'b0;
      ex_alu_op  <= '0;
      alusrc_q   <= 1'b0;
      sel1_q     <= '0;
      sel2_q     <= '0;
      rs_data_q  <= '0;
      rt_data_q  <= '0;
      imm_q      <= '0;
      if (rst) begin
        hold_opa   <= '0;
        hold_opb   <= '0;
        hold_store <= '0;
      end
    end else if (stall_in) begin
      if (state == RUN) begin
        hold_opa   <= rs_v;
        hold_opb   <= opb_v;
        hold_store <= rt_v;
      end
      state <= HOLD;
    end else begin
      state <= RUN;
      if (load_use_stall) begin
        ex_valid  <= 1'b0;
        ex_rd     <= '0;
        ex_regw   <= 1'b0;
        ex_memr   <= 1'b0;
        ex_memw   <= 1'b0;
        ex_alu_op <= '0;
        alusrc_q  <= 1'b0;
        sel1_q    <= '0;
        sel2_q    <= '0;
        rs_data_q <= '0;
        rt_data_q <= '0;
        imm_q     <= '0;
      end else begin
        ex_valid  <= id_valid;
        ex_rd     <= id_rd;
        ex_regw   <= id_regw;
        ex_memr   <= id_memr;
        ex_memw   <= id_memw;
        ex_alu_op <= id_alu_op;
        alusrc_q  <= id_alusrc;
        sel1_q    <= fwd_sel1;
        sel2_q    <= fwd_sel2;
        rs_data_q <= id_rs_data;
        rt_data_q <= id_rt_data;
        imm_q     <= id_imm;
      end
    end
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
ID/EX pipeline register and EX-operand resolver for the 5-stage pipeline.
- Captures decoded operands, register indices and control from ID, together with the 2-bit forwarding selects that the forwarding unit computes in ID.
- Applies those selects in EX to produce the ALU operands and store data.
- Detects load-use hazards, inserts a one-cycle bubble and raises a stall to the PC/IF-ID registers.
- Drives ex_rd/ex_regw, which feed the forwarding unit's EX-stage inputs.

Parameters:
DATA_W, 32, operand/result width
REG_W, 5, register index width
ALUOP_W, 4, ALU opcode width

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous, active-high reset
stall_in  in  1  external hold (e.g. memory busy); freeze stage
flush_in  in  1  branch/jump flush; load bubble
id_valid  in  1  ID holds a real instruction
id_rs_data  in  DATA_W  register-file Rs value
id_rt_data  in  DATA_W  register-file Rt value
id_imm  in  DATA_W  sign/zero-extended immediate
id_rs, id_rt, id_rd  in  REG_W  each  source/destination indices
id_uses_rt  in  1  instruction reads Rt
id_regw, id_memr, id_memw, id_alusrc  in  1 each  control
id_alu_op  in  ALUOP_W  ALU operation
fwd_sel1, fwd_sel2  in  2 each  forwarding selects for Rs/Rt (00 regfile, 10 EX result, 01 MEM result)
mem_alu_result  in  DATA_W  EX/MEM ALU result (current cycle)
wb_data  in  DATA_W  MEM/WB writeback data (current cycle)
load_use_stall  out  1  hold PC and IF/ID this cycle
ex_valid  out  1  EX holds a real instruction
ex_rd  out  REG_W  EX destination index
ex_regw, ex_memr, ex_memw  out  1 each  EX control
ex_alu_op  out  ALUOP_W  ALU operation
ex_opa  out  DATA_W  resolved ALU operand A
ex_opb  out  DATA_W  resolved ALU operand B
ex_store_data  out  DATA_W  resolved Rt for stores

Behaviour:
- Reset (rst=1 at edge):
  - All registered fields cleared: ex_valid=0, ex_rd=0, all control=0, ex_alu_op=0.
  - Latched selects=00, latched data=0; FSM=RUN.
  - Hence ex_opa=ex_opb=ex_store_data=0 and load_use_stall=0 from the following cycle.
  - rst mid-stall or mid-bubble discards everything.
- Load-use detect (combinational):
  - load_use_stall = ex_valid & ex_memr & ex_rd!=0 & (ex_rd==id_rs | (id_uses_rt & ex_rd==id_rt)).
  - Forced 0 when FSM=HOLD or stall_in=1.
- Edge update priority: rst > flush_in > stall_in > load_use_stall > capture.
  - flush_in: load bubble (valid=0, regw/memr/memw=0, rd=0, selects=00). Takes priority even over stall_in; FSM goes to RUN.
  - stall_in: registers unchanged; FSM RUN->HOLD. On that edge, capture the current resolved opa_rt/opb/store values into hold registers.
  - load_use_stall: load bubble. The next cycle the load is in MEM; the forwarding unit then issues 01 for the consumer, which resolves from wb_data one cycle later.
  - capture: latch all id_* fields and fwd_sel1/2; valid=id_valid.
- Operand resolution in RUN (EX cycle):
  - rs_v: sel1=10 -> mem_alu_result; 01 -> wb_data; 00 or 11 -> latched id_rs_data.
  - rt_v resolved the same way from sel2.
  - ex_opa=rs_v; ex_store_data=rt_v; ex_opb = alusrc ? latched imm : rt_v.
  - The EX-producer has advanced to EX/MEM and the MEM-producer to MEM/WB, hence this mapping.
- FSM:
  - RUN: outputs from the live mux.
  - HOLD: outputs from the hold registers, not the mux, because upstream producers keep moving.
  - HOLD->RUN when stall_in=0 at an edge. On that same edge the stage captures/bubbles normally by the priority above.
- Zero register: sel values are trusted; no re-check of index 0 here.
- Latency: ID fields appear on ex_* one cycle after capture.

Test Plan:
- Reset: rst=1 one cycle with id_valid=1, id_regw=1 -> next cycle ex_valid=0, ex_regw=0, ex_opa=0, load_use_stall=0.
- Plain capture: id_rs_data=0x11, id_rt_data=0x22, alusrc=0, sel=00/00 -> next cycle ex_opa=0x11, ex_opb=0x22, ex_rd=id_rd.
- EX forward: sel1=10 captured; next cycle mem_alu_result=0xDEAD -> ex_opa=0xDEAD. MEM forward: sel2=01, wb_data=0xBEEF -> ex_store_data=0xBEEF; with alusrc=1, ex_opb=id_imm.
- Load-use: EX holds lw to $8 (memr=1, valid=1); ID add reads rs=$8 -> load_use_stall=1; next cycle ex_valid=0, regw=0. Repeat with rd=0 -> no stall. Repeat with id_uses_rt=0, rt=$8 -> no stall.
- Hold: capture with sel1=10, mem_alu_result=0x5; assert stall_in 3 cycles while mem_alu_result changes to 0x9 -> ex_opa stays 0x5 throughout; release -> new ID instruction captured next edge.
- Simultaneous: flush_in=1 and stall_in=1 -> bubble loaded, FSM=RUN. Flush with load-use condition true -> bubble, load_use_stall=1 that cycle only.
